// File: rtl/stream_mux_nx1_if.sv
// rtl/stream_mux_nx1_if.sv - handshake bundle between N producers, the mux and one consumer
interface stream_mux_nx1_if #(
    parameter int N = 3,
    parameter int W = 8
);
    localparam int SELW = $clog2(N);

    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic            sel_force_en;
    logic [SELW-1:0] sel_force;
    logic [W-1:0]    out_data;
    logic [SELW-1:0] out_sel;
    logic            out_valid;
    logic            out_ready;

    modport master (
        output in_data, in_valid, sel_force_en, sel_force, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );

    modport slave (
        input  in_data, in_valid, sel_force_en, sel_force, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );
endinterface

// File: rtl/stream_mux_nx1.sv
// rtl/stream_mux_nx1.sv - N:1 registered stream mux with fixed-priority/round-robin arbitration and forced select
module stream_mux_nx1 #(
    parameter int N    = 3,
    parameter int W    = 8,
    parameter int MODE = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    stream_mux_nx1_if.slave bus
);
    localparam int SELW = $clog2(N);
    localparam logic [SELW-1:0] RR_RESET = SELW'(N - 1);

    logic [W-1:0]    out_data_q,  out_data_d;
    logic [SELW-1:0] out_sel_q,   out_sel_d;
    logic            out_valid_q, out_valid_d;
    logic [SELW-1:0] rr_ptr_q,    rr_ptr_d;

    logic            load_en;
    logic            found;
    logic [N-1:0]    grant;
    logic [N-1:0]    ready;
    logic [SELW-1:0] grant_idx;
    logic [W-1:0]    grant_data;
    logic            xfer;

    assign load_en = ~out_valid_q | bus.out_ready;

    always_comb begin : arbitrate
        grant = '0;
        found = 1'b0;
        if (bus.sel_force_en) begin
            // Out-of-range sel_force matches no index, so it simply yields no grant.
            for (int i = 0; i < N; i++) begin
                if (bus.sel_force == SELW'(i) && bus.in_valid[i]) begin
                    grant[i] = 1'b1;
                end
            end
        end else if (MODE == 0) begin
            for (int i = 0; i < N; i++) begin
                if (!found && bus.in_valid[i]) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end else begin
            // Wrapping search split in two passes: indices above the pointer, then from 0 up to it.
            for (int i = 0; i < N; i++) begin
                if (!found && bus.in_valid[i] && (SELW'(i) > rr_ptr_q)) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!found && bus.in_valid[i] && (SELW'(i) <= rr_ptr_q)) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

    always_comb begin : select
        grant_idx  = '0;
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                grant_idx  = SELW'(i);
                grant_data = bus.in_data[i*W +: W];
            end
        end
    end

    // rst_n gates ready so no handshake can complete while reset is held.
    assign ready        = grant & {N{load_en & rst_n}};
    assign xfer         = |ready;
    assign bus.in_ready = ready;

    always_comb begin : next_state
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            out_data_d  = grant_data;
            out_sel_d   = grant_idx;
            out_valid_d = 1'b1;
            if (MODE == 1) begin
                rr_ptr_d = grant_idx;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= RR_RESET;
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_stream_mux_nx1.sv
// tb/tb_stream_mux_nx1.sv - bench for stream_mux_nx1: vector table, hand sequences, randomized scoreboard
module tb_stream_mux_nx1;
    logic clk = 1'b0;
    logic rst0, rst1, rst2;
    int   n_checks = 0;
    int   n_err    = 0;

    always #5 clk = ~clk;

    stream_mux_nx1_if #(.N(3),  .W(8))  if0 ();
    stream_mux_nx1_if #(.N(3),  .W(8))  if1 ();
    stream_mux_nx1_if #(.N(16), .W(64)) if2 ();

    stream_mux_nx1 #(.N(3),  .W(8),  .MODE(0)) u0 (.clk(clk), .rst_n(rst0), .bus(if0));
    stream_mux_nx1 #(.N(3),  .W(8),  .MODE(1)) u1 (.clk(clk), .rst_n(rst1), .bus(if1));
    stream_mux_nx1 #(.N(16), .W(64), .MODE(1)) u2 (.clk(clk), .rst_n(rst2), .bus(if2));

    typedef struct {
        logic [2:0] valid;
        logic [7:0] d0, d1, d2;
        logic       ordy;
        logic       fe;
        logic [1:0] fs;
        logic [2:0] exp_ready;
        logic       exp_ov;
        logic [7:0] exp_od;
        logic [1:0] exp_os;
    } vec_t;

    typedef struct {
        logic [63:0] d;
        int          s;
    } sb_t;

    vec_t tbl[16];
    sb_t  q[$];

    logic [63:0] pdata[16];
    bit          pend[16];
    int          waitc[16];
    int          rr, g, c, max_wait, accepted;
    logic        ordy2;
    logic [15:0] exp_ready2;
    sb_t         e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    initial begin
        // valid   d0     d1     d2     rdy  fe    fs     ready   ov    od     os
        tbl[0]  = '{3'b110, 8'h11, 8'h22, 8'h33, 1'b1, 1'b0, 2'd0, 3'b010, 1'b1, 8'h22, 2'd1};
        tbl[1]  = '{3'b111, 8'h11, 8'h22, 8'h33, 1'b1, 1'b0, 2'd0, 3'b001, 1'b1, 8'h11, 2'd0};
        tbl[2]  = '{3'b000, 8'h11, 8'h22, 8'h33, 1'b1, 1'b0, 2'd0, 3'b000, 1'b0, 8'h11, 2'd0};
        tbl[3]  = '{3'b100, 8'h11, 8'h22, 8'h33, 1'b0, 1'b0, 2'd0, 3'b100, 1'b1, 8'h33, 2'd2};
        tbl[4]  = '{3'b011, 8'h11, 8'h22, 8'h33, 1'b0, 1'b0, 2'd0, 3'b000, 1'b1, 8'h33, 2'd2};
        tbl[5]  = '{3'b011, 8'h11, 8'h22, 8'h33, 1'b1, 1'b0, 2'd0, 3'b001, 1'b1, 8'h11, 2'd0};
        tbl[6]  = '{3'b111, 8'h11, 8'h22, 8'h33, 1'b1, 1'b1, 2'd2, 3'b100, 1'b1, 8'h33, 2'd2};
        tbl[7]  = '{3'b111, 8'h11, 8'h22, 8'h33, 1'b1, 1'b1, 2'd3, 3'b000, 1'b0, 8'h33, 2'd2};
        tbl[8]  = '{3'b101, 8'h11, 8'h22, 8'h33, 1'b1, 1'b1, 2'd1, 3'b000, 1'b0, 8'h33, 2'd2};
        tbl[9]  = '{3'b101, 8'h5A, 8'h22, 8'h33, 1'b0, 1'b1, 2'd0, 3'b001, 1'b1, 8'h5A, 2'd0};
        for (int i = 10; i < 14; i++)
            tbl[i] = '{3'b110, 8'h5A, 8'h66, 8'h33, 1'b0, 1'b0, 2'd0, 3'b000, 1'b1, 8'h5A, 2'd0};
        tbl[14] = '{3'b110, 8'h5A, 8'h66, 8'h33, 1'b1, 1'b0, 2'd0, 3'b010, 1'b1, 8'h66, 2'd1};
        tbl[15] = '{3'b000, 8'h5A, 8'h66, 8'h33, 1'b1, 1'b0, 2'd0, 3'b000, 1'b0, 8'h66, 2'd1};

        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        if0.in_data = '0; if0.in_valid = '0; if0.sel_force_en = 1'b0; if0.sel_force = '0; if0.out_ready = 1'b0;
        if1.in_data = '0; if1.in_valid = '0; if1.sel_force_en = 1'b0; if1.sel_force = '0; if1.out_ready = 1'b0;
        if2.in_data = '0; if2.in_valid = '0; if2.sel_force_en = 1'b0; if2.sel_force = '0; if2.out_ready = 1'b0;

        // Reset state of the fixed-priority instance, with inputs already active.
        @(negedge clk);
        if0.in_valid = 3'b111; if0.in_data = 24'h332211; if0.out_ready = 1'b1;
        @(posedge clk); #1;
        check("reset out_valid", if0.out_valid, 0);
        check("reset out_data",  if0.out_data,  0);
        check("reset out_sel",   if0.out_sel,   0);
        check("reset in_ready",  if0.in_ready,  0);
        @(negedge clk); rst0 = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if0.in_valid     = tbl[i].valid;
            if0.in_data      = {tbl[i].d2, tbl[i].d1, tbl[i].d0};
            if0.out_ready    = tbl[i].ordy;
            if0.sel_force_en = tbl[i].fe;
            if0.sel_force    = tbl[i].fs;
            #1;
            check($sformatf("row%0d in_ready", i), if0.in_ready, tbl[i].exp_ready);
            @(posedge clk); #1;
            check($sformatf("row%0d out_valid", i), if0.out_valid, tbl[i].exp_ov);
            check($sformatf("row%0d out_data", i),  if0.out_data,  tbl[i].exp_od);
            check($sformatf("row%0d out_sel", i),   if0.out_sel,   tbl[i].exp_os);
        end

        // Round-robin rotation with all channels valid.
        @(negedge clk); rst1 = 1'b1;
        @(negedge clk);
        if1.in_valid = 3'b111; if1.in_data = 24'hA2A1A0; if1.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check($sformatf("rr%0d out_sel", k),   if1.out_sel,   k % 3);
            check($sformatf("rr%0d out_valid", k), if1.out_valid, 1);
            check($sformatf("rr%0d out_data", k),  if1.out_data,  8'hA0 + k % 3);
        end
        // A forced grant moves the round-robin pointer too.
        @(negedge clk); if1.sel_force_en = 1'b1; if1.sel_force = 2'd1;
        @(posedge clk); #1; check("rr force out_sel", if1.out_sel, 1);
        @(negedge clk); if1.sel_force_en = 1'b0;
        @(posedge clk); #1; check("rr after force out_sel", if1.out_sel, 2);
        @(posedge clk); #1; check("rr wrap out_sel", if1.out_sel, 0);

        // Reset while a word is held under back-pressure.
        @(negedge clk); if1.in_valid = 3'b001;
        @(posedge clk); #1; check("pre-reset out_sel", if1.out_sel, 0);
        @(negedge clk); if1.out_ready = 1'b0;
        #1; check("pre-reset in_ready", if1.in_ready, 0);
        check("pre-reset out_valid", if1.out_valid, 1);
        #2; rst1 = 1'b0;
        #1;
        check("async reset out_valid", if1.out_valid, 0);
        check("async reset out_data",  if1.out_data,  0);
        check("async reset in_ready",  if1.in_ready,  0);
        @(negedge clk); rst1 = 1'b1; if1.in_valid = 3'b111; if1.out_ready = 1'b1;
        #1; check("post-reset in_ready", if1.in_ready, 3'b001);
        @(posedge clk); #1;
        check("post-reset out_sel",   if1.out_sel,   0);
        check("post-reset out_data",  if1.out_data,  8'hA0);
        check("post-reset out_valid", if1.out_valid, 1);

        // Randomized 16x64 round-robin run against a queue-based model.
        @(negedge clk); rst2 = 1'b1;
        rr = 15; max_wait = 0; accepted = 0;
        for (int i = 0; i < 16; i++) begin pend[i] = 1'b0; waitc[i] = 0; pdata[i] = '0; end
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 16; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i]  = 1'b1;
                    pdata[i] = {$urandom, $urandom};
                    waitc[i] = 0;
                end
                if2.in_valid[i]         = pend[i];
                if2.in_data[i*64 +: 64] = pdata[i];
            end
            ordy2 = ($urandom_range(0, 3) != 0);
            if2.out_ready = ordy2;
            #1;
            g = -1;
            if (q.size() == 0 || ordy2) begin
                for (int k = 1; k <= 16; k++) begin
                    c = (rr + k) % 16;
                    if (g < 0 && pend[c]) g = c;
                end
            end
            exp_ready2 = (g >= 0) ? (16'd1 << g) : 16'd0;
            check("rand in_ready", if2.in_ready, exp_ready2);
            check("rand out_valid", if2.out_valid, q.size() != 0);
            if (q.size() != 0 && ordy2) begin
                e = q.pop_front();
                check("rand out_data", if2.out_data, e.d);
                check("rand out_sel",  if2.out_sel,  e.s);
            end
            if (g >= 0) begin
                e.d = pdata[g];
                e.s = g;
                q.push_back(e);
                if (waitc[g] > max_wait) max_wait = waitc[g];
                pend[g] = 1'b0;
                rr = g;
                accepted++;
                for (int i = 0; i < 16; i++) if (pend[i]) waitc[i]++;
            end
        end
        check("rand accepted>100", accepted > 100, 1);
        check("rand max wait<=16", max_wait <= 16, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
